// File: rtl/memory_write_control.sv
// Write-side controller of the frame memory: decimates the incoming video stream 2:1
// in both directions and writes surviving pixels row-major into the frame buffer.
module memory_write_control #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_DEPTH = 512*512/4,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  rst_n,
    input  logic                  i_frame_en,
    input  logic                  i_vsync,
    input  logic                  i_hsync,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [10:0]           i_hres,
    input  logic [10:0]           i_vres,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_err
);

    localparam logic [1:0] S_WIDLE   = 2'd0;
    localparam logic [1:0] S_WWAIT   = 2'd1;
    localparam logic [1:0] S_WACTIVE = 2'd2;
    localparam logic [1:0] S_WDONE   = 2'd3;

    localparam logic [ADDR_WIDTH:0] WPTR_FULL = (ADDR_WIDTH+1)'(ADDR_DEPTH);
    localparam logic [ADDR_WIDTH:0] WPTR_ONE  = (ADDR_WIDTH+1)'(1);

    logic [1:0]            state_q, state_d;
    logic                  vs_q;
    logic                  de_q, de_d;
    logic [11:0]           col_cnt_q, col_cnt_d;
    logic [11:0]           row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Line sync carries no information the de-based counters need.
    logic unused_hsync;
    assign unused_hsync = i_hsync;

    logic        vs_rise;
    logic        de_fall;
    logic [11:0] hres_ext;
    logic [11:0] vres_ext;
    logic [11:0] row_next;
    logic        in_active;
    logic        candidate;
    logic        wptr_full;

    always_comb begin
        vs_rise   = i_vsync & ~vs_q;
        de_fall   = de_q & ~i_de;
        hres_ext  = {1'b0, i_hres};
        vres_ext  = {1'b0, i_vres};
        row_next  = row_cnt_q + 12'd1;
        in_active = (state_q == S_WACTIVE);
        wptr_full = (wptr_q == WPTR_FULL);
        candidate = in_active & i_de & ~col_cnt_q[0] & ~row_cnt_q[0] &
                    (col_cnt_q < hres_ext) & (row_cnt_q < vres_ext);
    end

    always_comb begin
        state_d   = state_q;
        de_d      = 1'b0;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        wptr_d    = wptr_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_WIDLE: begin
                state_d = S_WWAIT;
            end

            S_WWAIT: begin
                if (vs_rise && i_frame_en) begin
                    state_d   = S_WACTIVE;
                    col_cnt_d = 12'd0;
                    row_cnt_d = 12'd0;
                    wptr_d    = '0;
                    err_d     = 1'b0;
                end
            end

            S_WACTIVE: begin
                if (vs_rise) begin
                    // Early vsync: abandon the partial frame, restart from the top.
                    err_d     = 1'b1;
                    col_cnt_d = 12'd0;
                    row_cnt_d = 12'd0;
                    wptr_d    = '0;
                    state_d   = i_frame_en ? S_WACTIVE : S_WWAIT;
                end else begin
                    de_d = i_de;
                    if (i_de) begin
                        col_cnt_d = col_cnt_q + 12'd1;
                    end else if (de_fall) begin
                        col_cnt_d = 12'd0;
                        row_cnt_d = row_next;
                        if (row_next == vres_ext) begin
                            state_d = S_WDONE;
                            done_d  = 1'b1;
                        end
                    end

                    if (candidate) begin
                        if (wptr_full) begin
                            err_d = 1'b1;
                        end else begin
                            wen_d   = 1'b1;
                            waddr_d = wptr_q[ADDR_WIDTH-1:0];
                            wdata_d = i_data;
                            wptr_d  = wptr_q + WPTR_ONE;
                        end
                    end
                end
            end

            S_WDONE: begin
                state_d = S_WWAIT;
            end

            default: begin
                state_d = S_WIDLE;
            end
        endcase

        busy_d = (state_d == S_WACTIVE);
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WIDLE;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            col_cnt_q <= 12'd0;
            row_cnt_q <= 12'd0;
            wptr_q    <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_q      <= i_vsync;
            de_q      <= de_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            wptr_q    <= wptr_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_wen        = wen_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_memory_write_control.sv
// Directed bench for memory_write_control: a default-depth instance plus a 4-entry
// instance sharing the same stimulus, the latter used for address overflow.
module tb_memory_write_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_en;
    logic        vsync;
    logic        hsync;
    logic        de;
    logic [23:0] data;
    logic [10:0] hres;
    logic [10:0] vres;

    logic        wen, busy, done, err;
    logic [15:0] waddr;
    logic [23:0] wdata;
    logic        s_wen, s_busy, s_done, s_err;
    logic [1:0]  s_waddr;
    logic [23:0] s_wdata;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int          m_addr[$];
    logic [23:0] m_data[$];
    int          m_done;
    int          m_busy_seen;
    logic        m_err_at_done;
    int          s_addr[$];
    logic [23:0] s_data[$];
    int          s_done_cnt;
    logic        s_err_at_done;

    always #5 clk = ~clk;

    memory_write_control #(.DATA_WIDTH(24)) dut (
        .i_clk(clk), .rst_n(rst_n), .i_frame_en(frame_en), .i_vsync(vsync),
        .i_hsync(hsync), .i_de(de), .i_data(data), .i_hres(hres), .i_vres(vres),
        .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata), .o_busy(busy),
        .o_frame_done(done), .o_err(err)
    );

    memory_write_control #(.DATA_WIDTH(24), .ADDR_DEPTH(4)) dut_small (
        .i_clk(clk), .rst_n(rst_n), .i_frame_en(frame_en), .i_vsync(vsync),
        .i_hsync(hsync), .i_de(de), .i_data(data), .i_hres(hres), .i_vres(vres),
        .o_wen(s_wen), .o_waddr(s_waddr), .o_wdata(s_wdata), .o_busy(s_busy),
        .o_frame_done(s_done), .o_err(s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (wen) begin
            m_addr.push_back(int'(waddr));
            m_data.push_back(wdata);
        end
        if (done) begin
            m_done++;
            m_err_at_done = err;
        end
        if (busy) m_busy_seen++;
        if (s_wen) begin
            s_addr.push_back(int'(s_waddr));
            s_data.push_back(s_wdata);
        end
        if (s_done) begin
            s_done_cnt++;
            s_err_at_done = s_err;
        end
    endtask

    task automatic clear_logs();
        m_addr.delete();
        m_data.delete();
        s_addr.delete();
        s_data.delete();
        m_done = 0;
        m_busy_seen = 0;
        m_err_at_done = 1'b0;
        s_done_cnt = 0;
        s_err_at_done = 1'b0;
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive_line(input int row, input int npix);
        for (int c = 0; c < npix; c++) begin
            de = 1'b1;
            data = 24'(row * 16 + c);
            tick();
        end
        de = 1'b0;
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive_lines(input int first, input int n, input int npix);
        for (int r = first; r < first + n; r++) drive_line(r, npix);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %b want 0", wen); end else passes++;
        checks++; if (waddr !== 16'd0) begin fails++; $display("FAIL reset_waddr got %0h want 0", waddr); end else passes++;
        checks++; if (wdata !== 24'd0) begin fails++; $display("FAIL reset_wdata got %0h want 0", wdata); end else passes++;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end else passes++;
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end else passes++;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end else passes++;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        logic [23:0] exp_data [8] = '{24'h00, 24'h02, 24'h04, 24'h06, 24'h20, 24'h22, 24'h24, 24'h26};
        hres = 11'd8;
        vres = 11'd4;
        clear_logs();
        frame_start();
        drive_lines(0, 4, 8);
        checks++; if (m_addr.size() !== 8) begin fails++; $display("FAIL basic_count got %0d want 8", m_addr.size()); end else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++; if (m_addr[i] !== i) begin fails++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, m_addr[i], i); end else passes++;
            checks++; if (m_data[i] !== exp_data[i]) begin fails++; $display("FAIL basic_data[%0d] got %0h want %0h", i, m_data[i], exp_data[i]); end else passes++;
        end
        checks++; if (m_done !== 1) begin fails++; $display("FAIL basic_done got %0d want 1", m_done); end else passes++;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", err); end else passes++;
    endtask

    task automatic test_latency();
        hres = 11'd2;
        vres = 11'd2;
        clear_logs();
        frame_start();
        de = 1'b1;
        data = 24'h55;
        checks++; if (wen !== 1'b0) begin fails++; $display("FAIL lat_wen_before got %b want 0", wen); end else passes++;
        tick();
        checks++; if (wen !== 1'b1) begin fails++; $display("FAIL lat_wen_rise got %b want 1", wen); end else passes++;
        checks++; if (waddr !== 16'd0) begin fails++; $display("FAIL lat_waddr got %0h want 0", waddr); end else passes++;
        checks++; if (wdata !== 24'h55) begin fails++; $display("FAIL lat_wdata got %0h want 55", wdata); end else passes++;
        data = 24'h66;
        tick();
        checks++; if (wen !== 1'b0) begin fails++; $display("FAIL lat_wen_odd got %b want 0", wen); end else passes++;
        checks++; if (wdata !== 24'h55) begin fails++; $display("FAIL lat_wdata_hold got %0h want 55", wdata); end else passes++;
        de = 1'b0;
        tick();
        de = 1'b1;
        data = 24'h77;
        tick();
        tick();
        de = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL lat_busy_before got %b want 1", busy); end else passes++;
        tick();
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL lat_done got %b want 1", done); end else passes++;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL lat_busy_at_done got %b want 0", busy); end else passes++;
        tick();
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL lat_done_pulse got %b want 0", done); end else passes++;
        checks++; if (m_addr.size() !== 1) begin fails++; $display("FAIL lat_count got %0d want 1", m_addr.size()); end else passes++;
    endtask

    task automatic test_early_vsync();
        hres = 11'd4;
        vres = 11'd4;
        clear_logs();
        frame_start();
        drive_lines(0, 2, 4);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL early_err_before got %b want 0", err); end else passes++;
        frame_start();
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL early_err_set got %b want 1", err); end else passes++;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL early_busy got %b want 1", busy); end else passes++;
        clear_logs();
        drive_lines(0, 4, 4);
        checks++; if (m_addr.size() !== 4) begin fails++; $display("FAIL early_count got %0d want 4", m_addr.size()); end else passes++;
        checks++; if (m_addr[0] !== 0) begin fails++; $display("FAIL early_first_addr got %0d want 0", m_addr[0]); end else passes++;
        checks++; if (m_addr[3] !== 3) begin fails++; $display("FAIL early_last_addr got %0d want 3", m_addr[3]); end else passes++;
        checks++; if (m_done !== 1) begin fails++; $display("FAIL early_done got %0d want 1", m_done); end else passes++;
        checks++; if (m_err_at_done !== 1'b1) begin fails++; $display("FAIL early_err_at_done got %b want 1", m_err_at_done); end else passes++;
        clear_logs();
        frame_start();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL early_err_clear got %b want 0", err); end else passes++;
        drive_lines(0, 4, 4);
        checks++; if (m_done !== 1) begin fails++; $display("FAIL early_next_done got %0d want 1", m_done); end else passes++;
        checks++; if (m_err_at_done !== 1'b0) begin fails++; $display("FAIL early_next_err got %b want 0", m_err_at_done); end else passes++;
    endtask

    task automatic test_overflow();
        hres = 11'd8;
        vres = 11'd4;
        clear_logs();
        frame_start();
        checks++; if (s_err !== 1'b0) begin fails++; $display("FAIL ovf_err_start got %b want 0", s_err); end else passes++;
        drive_line(0, 8);
        checks++; if (s_addr.size() !== 4) begin fails++; $display("FAIL ovf_row0_count got %0d want 4", s_addr.size()); end else passes++;
        checks++; if (s_err !== 1'b0) begin fails++; $display("FAIL ovf_err_row0 got %b want 0", s_err); end else passes++;
        drive_line(1, 8);
        drive_line(2, 8);
        checks++; if (s_err !== 1'b1) begin fails++; $display("FAIL ovf_err_set got %b want 1", s_err); end else passes++;
        checks++; if (s_addr.size() !== 4) begin fails++; $display("FAIL ovf_suppressed got %0d want 4", s_addr.size()); end else passes++;
        drive_line(3, 8);
        for (int i = 0; i < 4; i++) begin
            checks++; if (s_addr[i] !== i) begin fails++; $display("FAIL ovf_addr[%0d] got %0d want %0d", i, s_addr[i], i); end else passes++;
            checks++; if (s_data[i] !== 24'(2 * i)) begin fails++; $display("FAIL ovf_data[%0d] got %0h want %0h", i, s_data[i], 2 * i); end else passes++;
        end
        checks++; if (s_done_cnt !== 1) begin fails++; $display("FAIL ovf_done got %0d want 1", s_done_cnt); end else passes++;
        checks++; if (s_err_at_done !== 1'b1) begin fails++; $display("FAIL ovf_err_at_done got %b want 1", s_err_at_done); end else passes++;
    endtask

    task automatic test_overlong_enable();
        hres = 11'd8;
        vres = 11'd4;
        clear_logs();
        frame_start();
        drive_lines(0, 4, 10);
        checks++; if (m_addr.size() !== 8) begin fails++; $display("FAIL long_count got %0d want 8", m_addr.size()); end else passes++;
        checks++; if (m_addr[7] !== 7) begin fails++; $display("FAIL long_last_addr got %0d want 7", m_addr[7]); end else passes++;
        checks++; if (m_data[3] !== 24'h06) begin fails++; $display("FAIL long_data3 got %0h want 06", m_data[3]); end else passes++;
        checks++; if (m_data[4] !== 24'h20) begin fails++; $display("FAIL long_data4 got %0h want 20", m_data[4]); end else passes++;
        checks++; if (m_data[7] !== 24'h26) begin fails++; $display("FAIL long_data7 got %0h want 26", m_data[7]); end else passes++;
        checks++; if (m_done !== 1) begin fails++; $display("FAIL long_done got %0d want 1", m_done); end else passes++;
        frame_en = 1'b0;
        clear_logs();
        frame_start();
        drive_lines(0, 4, 8);
        checks++; if (m_addr.size() !== 0) begin fails++; $display("FAIL dis_count got %0d want 0", m_addr.size()); end else passes++;
        checks++; if (m_busy_seen !== 0) begin fails++; $display("FAIL dis_busy got %0d want 0", m_busy_seen); end else passes++;
        checks++; if (m_done !== 0) begin fails++; $display("FAIL dis_done got %0d want 0", m_done); end else passes++;
        frame_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        hres = 11'd8;
        vres = 11'd4;
        clear_logs();
        frame_start();
        drive_lines(0, 2, 8);
        de = 1'b1;
        data = 24'h20;
        tick();
        checks++; if (wen !== 1'b1) begin fails++; $display("FAIL rmid_wen_pre got %b want 1", wen); end else passes++;
        checks++; if (waddr !== 16'd4) begin fails++; $display("FAIL rmid_waddr_pre got %0d want 4", waddr); end else passes++;
        data = 24'h21;
        rst_n = 1'b0;
        #1;
        checks++; if (wen !== 1'b0) begin fails++; $display("FAIL rmid_wen got %b want 0", wen); end else passes++;
        checks++; if (waddr !== 16'd0) begin fails++; $display("FAIL rmid_waddr got %0h want 0", waddr); end else passes++;
        checks++; if (wdata !== 24'd0) begin fails++; $display("FAIL rmid_wdata got %0h want 0", wdata); end else passes++;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end else passes++;
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL rmid_done got %b want 0", done); end else passes++;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rmid_err got %b want 0", err); end else passes++;
        tick();
        rst_n = 1'b1;
        clear_logs();
        for (int c = 2; c < 8; c++) begin
            data = 24'(32 + c);
            tick();
        end
        de = 1'b0;
        tick();
        tick();
        drive_line(3, 8);
        checks++; if (m_addr.size() !== 0) begin fails++; $display("FAIL rmid_no_writes got %0d want 0", m_addr.size()); end else passes++;
        checks++; if (m_busy_seen !== 0) begin fails++; $display("FAIL rmid_busy_after got %0d want 0", m_busy_seen); end else passes++;
        hres = 11'd2;
        vres = 11'd2;
        clear_logs();
        frame_start();
        drive_lines(0, 2, 2);
        checks++; if (m_addr.size() !== 1) begin fails++; $display("FAIL rmid_next_count got %0d want 1", m_addr.size()); end else passes++;
        checks++; if (m_addr[0] !== 0) begin fails++; $display("FAIL rmid_next_addr got %0d want 0", m_addr[0]); end else passes++;
        checks++; if (m_done !== 1) begin fails++; $display("FAIL rmid_next_done got %0d want 1", m_done); end else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        frame_en = 1'b1;
        vsync = 1'b0;
        hsync = 1'b0;
        de = 1'b0;
        data = 24'd0;
        hres = 11'd8;
        vres = 11'd4;
        clear_logs();
        test_reset();
        test_basic();
        test_latency();
        test_early_vsync();
        test_overflow();
        test_overlong_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
